// File: rtl/ifu_bram_fetch_if.sv
// Fetch-unit bus: core request/response handshake plus the BRAM read port.
// slave is the fetch unit; master is the core/memory side that drives it.
interface ifu_bram_fetch_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_pc;
  logic              flush;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [XLEN-1:0]   ram_dout;
  logic              inst_valid;
  logic              inst_ready;
  logic [XLEN-1:0]   inst;
  logic [XLEN-1:0]   inst_pc;
  logic              inst_fault;
  logic [CNT_W-1:0]  fetch_cnt;

  modport slave (
    input  req_valid, req_pc, flush, ram_dout, inst_ready,
    output req_ready, ram_en, ram_addr, inst_valid, inst, inst_pc, inst_fault, fetch_cnt
  );

  modport master (
    output req_valid, req_pc, flush, ram_dout, inst_ready,
    input  req_ready, ram_en, ram_addr, inst_valid, inst, inst_pc, inst_fault, fetch_cnt
  );
endinterface

// File: rtl/ifu_bram_fetch.sv
// Instruction fetch unit in front of a 1-cycle-latency single-port BRAM.
// Byte PCs become word addresses; misaligned/out-of-range PCs return a fault NOP.
module ifu_bram_fetch #(
  parameter int              XLEN      = 32,
  parameter int              ADDR_W    = 10,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [XLEN-1:0] NOP_INST  = 32'h0000_0013,
  parameter int              CNT_W     = 32
) (
  input  logic           clk,
  input  logic           rst,
  ifu_bram_fetch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, FULL} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   inst_q;
  logic [XLEN-1:0]   inst_pc_q;
  logic              fault_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;

  logic [XLEN-1:0]   off;
  logic              pc_ok;
  logic              req_ready;
  logic              accept;
  logic              ram_en;
  logic              inst_valid;

  // Wrapping subtract makes PCs below BASE_ADDR look huge, so one range test covers both ends.
  assign off        = bus.req_pc - BASE_ADDR;
  assign pc_ok      = (bus.req_pc[1:0] == 2'b00) && ((off >> (ADDR_W + 2)) == '0);
  assign inst_valid = (state_q == FULL);
  assign req_ready  = !rst && !bus.flush &&
                      ((state_q == IDLE) || ((state_q == FULL) && bus.inst_ready));
  assign accept     = bus.req_valid && req_ready;
  assign ram_en     = accept && pc_ok;

  assign bus.req_ready  = req_ready;
  assign bus.ram_en     = ram_en;
  assign bus.ram_addr   = ram_en ? off[ADDR_W+1:2] : addr_q;
  assign bus.inst_valid = inst_valid;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_fault = fault_q;
  assign bus.fetch_cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
    end else begin
      // Delivery counts even in a flush cycle.
      if (inst_valid && bus.inst_ready) cnt_q <= cnt_q + CNT_W'(1);
      if (ram_en) addr_q <= off[ADDR_W+1:2];

      if (bus.flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          BUSY: begin
            inst_q    <= bus.ram_dout;
            inst_pc_q <= pc_q;
            fault_q   <= 1'b0;
            state_q   <= FULL;
          end
          IDLE, FULL: begin
            if (accept) begin
              if (pc_ok) begin
                pc_q    <= bus.req_pc;
                state_q <= BUSY;
              end else begin
                inst_q    <= NOP_INST;
                inst_pc_q <= bus.req_pc;
                fault_q   <= 1'b1;
                state_q   <= FULL;
              end
            end else if (state_q == FULL && bus.inst_ready) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifu_bram_fetch.sv
// Directed + random bench for ifu_bram_fetch against a timing-level reference model.
module tb_ifu_bram_fetch;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_bram_fetch_if #(.XLEN(32), .ADDR_W(10), .CNT_W(4)) bus ();

  ifu_bram_fetch #(.XLEN(32), .ADDR_W(10), .BASE_ADDR(BASE), .NOP_INST(NOP), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [1024];
  always @(posedge clk) if (bus.ram_en) bus.ram_dout <= mem[bus.ram_addr];

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding fetch that becomes visible at a known cycle.
  int          cyc_n = 0;
  bit          pend  = 0;
  int          pend_t;
  logic [31:0] p_inst, p_pc;
  bit          p_fault;
  int          cnt_m  = 0;
  logic [9:0]  addr_m = '0;
  int          deliv  = 0;

  bit          last_acc, last_en, o_valid, o_ready, o_fault;
  logic [9:0]  last_addr;
  logic [31:0] o_inst, o_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit rv, input logic [31:0] pc, input bit ir, input bit fl);
    logic [31:0] off;
    bit ok, vis, rdy, acc;
    rst = r; bus.req_valid = rv; bus.req_pc = pc; bus.inst_ready = ir; bus.flush = fl;
    #2;
    off = pc - BASE;
    ok  = (pc[1:0] == 2'b00) && (off < 32'd4096);
    vis = pend && (cyc_n >= pend_t);
    rdy = !r && !fl && (!pend || (vis && ir));
    acc = rv && rdy;
    o_valid = bus.inst_valid; o_ready = bus.req_ready; o_fault = bus.inst_fault;
    o_inst  = bus.inst;       o_pc    = bus.inst_pc;
    chk("req_ready", 32'(bus.req_ready), 32'(rdy));
    chk("inst_valid", 32'(bus.inst_valid), 32'(vis));
    if (vis) begin
      chk("inst", bus.inst, p_inst);
      chk("inst_pc", bus.inst_pc, p_pc);
      chk("inst_fault", 32'(bus.inst_fault), 32'(p_fault));
    end
    chk("ram_en", 32'(bus.ram_en), 32'(acc && ok));
    if (acc && ok) addr_m = off[11:2];
    chk("ram_addr", 32'(bus.ram_addr), 32'(addr_m));
    chk("fetch_cnt", 32'(bus.fetch_cnt), 32'(cnt_m));
    last_acc = acc; last_en = bus.ram_en; last_addr = bus.ram_addr;
    if (vis && ir) begin
      cnt_m = (cnt_m + 1) % 16; pend = 0; deliv++;
    end
    if (fl) pend = 0;
    if (acc) begin
      pend    = 1;
      pend_t  = cyc_n + (ok ? 2 : 1);
      p_inst  = ok ? mem[off[11:2]] : NOP;
      p_pc    = pc;
      p_fault = !ok;
    end
    if (r) begin
      pend = 0; cnt_m = 0; addr_m = '0;
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] b [3];
    b[0] = BASE + 32'h0FFC; b[1] = BASE + 32'h1000; b[2] = BASE - 32'd4;
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE + 32'($urandom_range(0, 1023)) * 4;
      3:       return BASE + 32'($urandom_range(0, 4095));
      4:       return 32'($urandom);
      default: return b[$urandom_range(0, 2)];
    endcase
  endfunction

  initial begin
    logic [31:0] fp [3];
    int nacc;
    for (int i = 0; i < 1024; i++) mem[i] = 32'($urandom);
    mem[5] = 32'h0050_0093;
    rst = 1'b1; bus.req_valid = 1'b0; bus.req_pc = '0; bus.inst_ready = 1'b0; bus.flush = 1'b0;
    @(posedge clk); #1;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) cyc(1, 1, BASE, 1, 0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_fault", 32'(bus.inst_fault), 32'h0);

    // Basic fetch
    cyc(0, 1, BASE + 32'h14, 1, 0);
    chk("basic_en", 32'(last_en), 32'h1);
    chk("basic_addr", 32'(last_addr), 32'd5);
    cyc(0, 0, 32'h0, 1, 0);
    chk("basic_busy_valid", 32'(o_valid), 32'h0);
    cyc(0, 0, 32'h0, 1, 0);
    chk("basic_valid", 32'(o_valid), 32'h1);
    chk("basic_inst", o_inst, 32'h0050_0093);
    chk("basic_pc", o_pc, BASE + 32'h14);
    chk("basic_cnt", 32'(bus.fetch_cnt), 32'd1);

    // Back-to-back with 3-cycle stall
    cyc(0, 1, BASE, 0, 0);
    cyc(0, 1, BASE + 4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, BASE + 4, 0, 0);
      chk("stall_inst", o_inst, mem[0]);
      chk("stall_ready", 32'(o_ready), 32'h0);
    end
    cyc(0, 1, BASE + 4, 1, 0);
    chk("b2b_accept", 32'(last_acc), 32'h1);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
    chk("b2b_second", o_inst, mem[1]);
    chk("b2b_cnt", 32'(bus.fetch_cnt), 32'd3);

    // Fault responses
    fp[0] = BASE + 32'h2; fp[1] = BASE + 32'h1000; fp[2] = 32'h7FFF_FFFC;
    foreach (fp[k]) begin
      cyc(0, 1, fp[k], 1, 0);
      chk("fault_no_en", 32'(last_en), 32'h0);
      cyc(0, 0, 32'h0, 1, 0);
      chk("fault_valid", 32'(o_valid), 32'h1);
      chk("fault_inst", o_inst, NOP);
      chk("fault_flag", 32'(o_fault), 32'h1);
      chk("fault_pc", o_pc, fp[k]);
    end

    // Flush during BUSY
    cyc(0, 1, BASE + 32'h8, 1, 0);
    cyc(0, 0, 32'h0, 1, 1);
    cyc(0, 0, 32'h0, 1, 0);
    chk("flush_valid", 32'(o_valid), 32'h0);
    cyc(0, 1, BASE + 32'hC, 1, 0);
    chk("flush_next_acc", 32'(last_acc), 32'h1);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
    chk("flush_next_inst", o_inst, mem[3]);

    // Counter wrap at CNT_W=4
    cyc(1, 0, 32'h0, 0, 0);
    deliv = 0; nacc = 0;
    for (int k = 0; k < 100 && deliv < 17; k++) begin
      cyc(0, nacc < 17, BASE + 32'(nacc) * 4, 1, 0);
      if (last_acc) nacc++;
    end
    chk("wrap_deliv", 32'(deliv), 32'd17);
    chk("wrap_cnt", 32'(bus.fetch_cnt), 32'd1);

    // Reset mid-BUSY drops the RAM result
    cyc(0, 1, BASE + 32'h10, 1, 0);
    cyc(1, 0, 32'h0, 1, 0);
    chk("midrst_valid", 32'(bus.inst_valid), 32'h0);
    chk("midrst_inst", bus.inst, 32'h0);
    chk("midrst_pc", bus.inst_pc, 32'h0);
    chk("midrst_cnt", 32'(bus.fetch_cnt), 32'h0);
    chk("midrst_addr", 32'(bus.ram_addr), 32'h0);
    cyc(0, 0, 32'h0, 1, 0);

    // Random traffic
    for (int k = 0; k < 800; k++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, rand_pc(),
          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu_bram_fetch.md
Name: ifu_bram_fetch

Overview:
- Parametrised instruction-fetch unit between the NPC core and a synchronous single-port block RAM holding program memory.
- Replaces ad-hoc per-clock instruction reads with a request/response handshake.
- Handles the RAM's 1-cycle read latency and translates byte PCs into RAM word addresses.
- Checks alignment and range, supports pipeline flush, and keeps a delivered-instruction counter.

Parameters:
- XLEN, 32: PC and instruction width.
- ADDR_W, 10: RAM word-address width. Memory depth is 2^ADDR_W words.
- BASE_ADDR, 32'h8000_0000: byte address mapped to RAM word 0.
- NOP_INST, 32'h0000_0013: instruction returned on a fault.
- CNT_W, 32: width of the fetch counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  core presents a fetch PC.
- req_ready  out  1  unit accepts the PC this cycle.
- req_pc  in  XLEN  byte PC to fetch.
- flush  in  1  discard any in-flight or held fetch.
- ram_en  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM word address.
- ram_dout  in  XLEN  RAM read data, valid 1 cycle after ram_en.
- inst_valid  out  1  fetched instruction available.
- inst_ready  in  1  core consumes the instruction.
- inst  out  XLEN  fetched instruction.
- inst_pc  out  XLEN  PC of inst.
- inst_fault  out  1  inst is a fault NOP (misaligned or out of range).
- fetch_cnt  out  CNT_W  count of delivered instructions.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - inst_valid, inst_fault, ram_en = 0.
  - inst, inst_pc, ram_addr, fetch_cnt = 0.
  - req_ready = 0 while rst=1.
  - rst overrides every other input, including mid-fetch: the RAM result is dropped.
- States:
  - IDLE: no fetch outstanding.
  - BUSY: RAM read issued in the previous cycle.
  - FULL: instruction held on the outputs.
- req_ready = !rst && !flush && (state==IDLE || (state==FULL && inst_ready)).
- Request accept (req_valid && req_ready):
  - off = req_pc - BASE_ADDR, computed in XLEN bits with wrap.
  - Valid PC: req_pc[1:0]==0 and off < 4*2^ADDR_W. Then ram_en=1 and ram_addr=off[ADDR_W+1:2], both combinational in the accept cycle. Latch pc; next state BUSY.
  - Fault PC (misaligned or out of range): no RAM access, ram_en=0. Next cycle: inst=NOP_INST, inst_pc=req_pc, inst_fault=1, state FULL.
- BUSY: inst <= ram_dout, inst_pc <= latched pc, inst_fault <= 0; next state FULL. req_ready=0.
- FULL: inst_valid=1. inst, inst_pc and inst_fault are stable until consumed.
  - inst_ready=1 with no new accept: next state IDLE.
  - inst_ready=1 with a new accept in the same cycle: next state BUSY (or FULL for a fault PC).
- Latency and throughput:
  - Accept to inst_valid is 2 cycles on the RAM path and 1 cycle on the fault path.
  - Peak throughput is one instruction per 2 cycles.
- Counter: fetch_cnt increments by 1 on each cycle where inst_valid && inst_ready, including faults. It wraps to 0 after all-ones.
- Flush:
  - Next state is IDLE from any state, and inst_valid=0 on the next cycle.
  - A RAM result in flight is discarded.
  - req_ready=0 during the flush cycle, so flush beats a simultaneous request.
  - A handshake on inst in the flush cycle still counts in fetch_cnt.
- ram_en is high only in the accept cycle of a valid PC. ram_addr holds its last value otherwise.
- Outputs are registered except req_ready, ram_en and ram_addr.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with req_valid=1 -> req_ready=0, inst_valid=0, fetch_cnt=0, no ram_en pulse.
2. Basic fetch: preload RAM word 5 = 32'h00500093; request req_pc=32'h8000_0014 with inst_ready=1 -> ram_en=1 and ram_addr=5 in the accept cycle; 2 cycles later inst=32'h00500093, inst_pc=32'h8000_0014, inst_fault=0; fetch_cnt=1.
3. Back-to-back with stall:
   - Issue PCs 0x8000_0000 and 0x8000_0004, holding inst_ready=0 for 3 cycles on the first.
   - Required: inst stays stable and req_ready=0 while stalled.
   - Required: the second request is accepted in the same cycle inst_ready rises.
   - Required: both instructions are delivered in order and fetch_cnt=2.
4. Faults:
   - req_pc=32'h8000_0002 -> inst_valid 1 cycle later, inst=32'h13, inst_fault=1, no ram_en.
   - req_pc=32'h8000_1000 (end of 1024 words) -> same fault response.
   - req_pc=32'h7FFF_FFFC -> same fault response.
5. Flush: accept 0x8000_0008, assert flush in the BUSY cycle -> inst_valid never rises for it; state IDLE; next request 0x8000_000C returns word 3.
6. Counter wrap: CNT_W=4, deliver 17 instructions -> fetch_cnt=1. Also assert rst mid-BUSY -> outputs return to reset values next cycle.
